r29_int4: RTL and testbench
===========================

R29_INT4 -- requirements
Module: r29_int4

Interface
REQ-001 Parameter WORD_SIZE, default 4: operand width in bits; operands are unsigned.
REQ-002 Parameter REG_SIZE, default 16: width of each histogram counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clk2  input  1  reserved; no functional effect, no clock domain (single-clock design).
REQ-006 left_in  input  WORD_SIZE  operand A from the west neighbour.
REQ-007 top_in  input  WORD_SIZE  operand B from the north neighbour.
REQ-008 fsm_out_select_in  input  1  1 = count mode; 0 = hold/readout mode.
REQ-009 right_out  output  WORD_SIZE  registered copy of left_in, to the east neighbour.
REQ-010 bottom_out  output  WORD_SIZE  registered copy of top_in, to the south neighbour.
REQ-011 counter_out  output  29*REG_SIZE  concatenation of counters C0..C28, with C0 in bits [REG_SIZE-1:0] and Ck in bits [(k+1)*REG_SIZE-1 : k*REG_SIZE].

Function
REQ-012 Each rising edge SHALL register right_out <= left_in and bottom_out <= top_in (1-cycle systolic forward), independent of fsm_out_select_in.
REQ-013 Each rising edge SHALL also capture left_in, top_in and fsm_out_select_in into an internal stage-1 register (a_q, b_q, en_q).
REQ-014 Bin index SHALL be k = a_q + b_q - 2, computed at WORD_SIZE+1 bits with no overflow.
REQ-015 A hit SHALL exist only when en_q = 1, a_q != 0 and b_q != 0; any zero operand gives no hit (valid sums 2..30 map to k = 0..28).
REQ-016 On a hit, exactly Ck SHALL increment by 1 on the next rising edge; all other counters hold.
REQ-017 Latency: a pair presented before edge N is visible on counter_out after edge N+1 (2 edges total).
REQ-018 When en_q = 0, no counter SHALL change and counter_out SHALL stay stable.
REQ-019 counter_out SHALL be driven directly from the counter registers, with no extra output stage.
REQ-020 Counter overflow at 2^REG_SIZE-1 is governed by REQ-025.
REQ-021 A fsm_out_select_in toggle mid-stream SHALL affect only pairs sampled while it is high; pairs already in stage 1 still follow en_q.

Reset
REQ-022 When rst = 0, all counters, stage-1 registers (including en_q), right_out and bottom_out SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-023 After rst returns to 1, the first counting pair is the one sampled on the first rising edge; a pair in flight at reset assertion is discarded.

Configuration
REQ-024 The macro is R29_INT4_SAT_EN.
REQ-025 With R29_INT4_SAT_EN defined, a counter at all-ones SHALL stay at all-ones on a further hit. Without it, the counter SHALL wrap to 0.

Structure
REQ-026 Package r29_int4_pkg SHALL hold the WORD_SIZE and REG_SIZE defaults, the constant NUM_BINS = 29 and the constant BIN_OFFSET = 2.
REQ-027 Sub-module r29_int4_counter (REG_SIZE-bit counter with increment enable, async active-low clear and the R29_INT4_SAT_EN behaviour) SHALL be instantiated NUM_BINS times via generate.

Verification
REQ-028 Reset: hold rst = 0, then release -> right_out, bottom_out and all 29 counters read 0.
REQ-029 Forwarding: left_in = 4'hA, top_in = 4'h5 -> after 1 edge, right_out = 4'hA and bottom_out = 4'h5.
REQ-030 Single hit: mode = 1; (3,4) for 1 cycle, then (0,0) -> after 2 edges C5 = 1 and all other counters = 0.
REQ-031 Extremes and zeros: (1,1) x3, (15,15) x2, (0,9) x4 -> C0 = 3, C28 = 2, no other change.
REQ-032 Hold mode: fsm_out_select_in = 0 with random operands for 100 cycles -> counter_out unchanged, forwarding still active.
REQ-033 Overflow: (8,8) applied for 65,537 cycles -> C14 = 16'hFFFF with R29_INT4_SAT_EN defined, 16'h0001 without it.

Source files
------------

// File: rtl/r29_int4_pkg.sv
// r29_int4_pkg -- shared constants for the r29_int4 sum-histogram cell.
//   DEF_WORD_SIZE : default operand width (unsigned operands)
//   DEF_REG_SIZE  : default width of each histogram counter
//   NUM_BINS      : number of histogram bins (operand sums 2..30)
//   BIN_OFFSET    : smallest counted sum, subtracted to form the bin index
package r29_int4_pkg;

   localparam int unsigned DEF_WORD_SIZE = 4;
   localparam int unsigned DEF_REG_SIZE  = 16;
   localparam int unsigned NUM_BINS      = 29;
   localparam int unsigned BIN_OFFSET    = 2;

endpackage : r29_int4_pkg

// File: rtl/r29_int4_counter.sv
// r29_int4_counter -- one histogram bin counter.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low clear
//   inc_i   : add one on the next rising edge
//   count_o : current count, straight from the register
// Overflow: with R29_INT4_SAT_EN defined the count sticks at all-ones,
// otherwise it wraps to zero.
module r29_int4_counter
   import r29_int4_pkg::*;
#(
   parameter int unsigned REG_SIZE = DEF_REG_SIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc_i,
   output logic [REG_SIZE-1:0] count_o
);

   logic [REG_SIZE-1:0] cnt_q;
   logic [REG_SIZE-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
`ifdef R29_INT4_SAT_EN
         if (cnt_q != '1) begin
            cnt_d = cnt_q + REG_SIZE'(1);
         end
`else
         cnt_d = cnt_q + REG_SIZE'(1);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule : r29_int4_counter

// File: rtl/r29_int4.sv
// r29_int4 -- systolic cell that forwards its operands one cycle east/south
// and histograms the operand sum a+b (sums 2..30) into 29 counters.
//   clk               : sole clock, rising edge
//   rst               : asynchronous active-low reset
//   clk2              : reserved, no functional effect
//   left_in / top_in  : unsigned operands A / B
//   fsm_out_select_in : 1 = count, 0 = hold/readout
//   right_out         : left_in delayed one cycle
//   bottom_out        : top_in delayed one cycle
//   counter_out       : C0..C28 concatenated, C0 in the low REG_SIZE bits
// Build option: define R29_INT4_SAT_EN for saturating counters (default wraps).
module r29_int4
   import r29_int4_pkg::*;
#(
   parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
   parameter int unsigned REG_SIZE  = DEF_REG_SIZE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk2,
   input  logic [WORD_SIZE-1:0]         left_in,
   input  logic [WORD_SIZE-1:0]         top_in,
   input  logic                         fsm_out_select_in,
   output logic [WORD_SIZE-1:0]         right_out,
   output logic [WORD_SIZE-1:0]         bottom_out,
   output logic [NUM_BINS*REG_SIZE-1:0] counter_out
);

   logic [WORD_SIZE-1:0] a_q;
   logic [WORD_SIZE-1:0] b_q;
   logic                 en_q;
   logic [WORD_SIZE:0]   sum_w;
   logic [WORD_SIZE:0]   bin_w;
   logic                 hit_w;
   logic [NUM_BINS-1:0]  inc_w;
   logic                 unused_clk2;

   assign unused_clk2 = clk2;

   // Stage 1: operand/enable capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q  <= '0;
         b_q  <= '0;
         en_q <= 1'b0;
      end else begin
         a_q  <= left_in;
         b_q  <= top_in;
         en_q <= fsm_out_select_in;
      end
   end

   // The forwarded operands are exactly the stage-1 operand registers.
   assign right_out  = a_q;
   assign bottom_out = b_q;

   // Bin decode: a zero operand never counts; the range check only matters
   // for WORD_SIZE > 4, where sums can exceed the last bin.
   always_comb begin
      sum_w = (WORD_SIZE+1)'(a_q) + (WORD_SIZE+1)'(b_q);
      bin_w = sum_w - (WORD_SIZE+1)'(BIN_OFFSET);
      hit_w = en_q && (a_q != '0) && (b_q != '0);
      inc_w = '0;
      for (int unsigned i = 0; i < NUM_BINS; i++) begin
         if (hit_w && (32'(bin_w) == i)) begin
            inc_w[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
      r29_int4_counter #(
         .REG_SIZE (REG_SIZE)
      ) u_cnt (
         .clk     (clk),
         .rst_n   (rst),
         .inc_i   (inc_w[g]),
         .count_o (counter_out[g*REG_SIZE +: REG_SIZE])
      );
   end

endmodule : r29_int4

// File: tb/tb_r29_int4.sv
// tb_r29_int4 -- directed self-checking bench for r29_int4 (default sizes).
module tb_r29_int4;

   localparam int unsigned W    = 4;
   localparam int unsigned R    = 16;
   localparam int unsigned BINS = 29;

   logic           clk;
   logic           rst;
   logic           clk2;
   logic [W-1:0]   left_in;
   logic [W-1:0]   top_in;
   logic           fsm_out_select_in;
   logic [W-1:0]   right_out;
   logic [W-1:0]   bottom_out;
   logic [BINS*R-1:0] counter_out;

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned exp_cnt [BINS];

   r29_int4 #(
      .WORD_SIZE (W),
      .REG_SIZE  (R)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .clk2              (clk2),
      .left_in           (left_in),
      .top_in            (top_in),
      .fsm_out_select_in (fsm_out_select_in),
      .right_out         (right_out),
      .bottom_out        (bottom_out),
      .counter_out       (counter_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int unsigned k);
      return 32'(counter_out[k*R +: R]);
   endfunction

   task automatic check_all(input string tag);
      for (int unsigned k = 0; k < BINS; k++) begin
         check($sformatf("%s C%0d", tag, k), cnt_of(k), exp_cnt[k]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one pair for one cycle and account for it in the expected histogram.
   task automatic apply(input int unsigned a, input int unsigned b, input logic en);
      int unsigned k;
      left_in           = W'(a);
      top_in            = W'(b);
      fsm_out_select_in = en;
      if (en && a != 0 && b != 0) begin
         k = a + b - 2;
`ifdef R29_INT4_SAT_EN
         if (exp_cnt[k] != 32'hFFFF) exp_cnt[k] = exp_cnt[k] + 1;
`else
         exp_cnt[k] = (exp_cnt[k] + 1) & 32'hFFFF;
`endif
      end
      step();
   endtask

   initial begin
      int unsigned l, t;
      n_tests = 0;
      n_fail  = 0;
      foreach (exp_cnt[k]) exp_cnt[k] = 0;
      clk2              = 1'b0;
      rst               = 1'b0;
      left_in           = 4'h7;
      top_in            = 4'h9;
      fsm_out_select_in = 1'b1;

      // Reset held with live inputs: everything stays cleared.
      repeat (3) step();
      check("rst_hold right", 32'(right_out), 32'h0);
      check("rst_hold bottom", 32'(bottom_out), 32'h0);
      check_all("rst_hold");
      left_in = '0; top_in = '0; fsm_out_select_in = 1'b0;
      rst = 1'b1;
      step();
      check("rst_rel right", 32'(right_out), 32'h0);
      check("rst_rel bottom", 32'(bottom_out), 32'h0);
      check_all("rst_rel");

      // Forwarding in hold mode.
      apply(4'hA, 4'h5, 1'b0);
      check("fwd right", 32'(right_out), 32'hA);
      check("fwd bottom", 32'(bottom_out), 32'h5);

      // Single hit: 3+4 -> C5, visible only after the second edge.
      apply(3, 4, 1'b1);
      check("lat C5 edge1", cnt_of(5), 32'h0);
      apply(0, 0, 1'b1);
      check_all("single");

      // Extremes and zero operands.
      repeat (3) apply(1, 1, 1'b1);
      repeat (2) apply(15, 15, 1'b1);
      repeat (4) apply(0, 9, 1'b1);
      apply(0, 0, 1'b0);
      check("ext C0", cnt_of(0), 32'd3);
      check("ext C28", cnt_of(28), 32'd2);
      check_all("ext");

      // Hold mode with random operands: forwarding continues, counts frozen.
      for (int i = 0; i < 100; i++) begin
         l = $urandom_range(15);
         t = $urandom_range(15);
         apply(l, t, 1'b0);
         check("hold right", 32'(right_out), l);
         check("hold bottom", 32'(bottom_out), t);
      end
      check_all("hold");

      // Mode drop mid-stream: only the pair sampled while high counts.
      apply(2, 2, 1'b1);
      apply(2, 2, 1'b0);
      apply(0, 0, 1'b0);
      check("toggle C2", cnt_of(2), 32'd1);
      check_all("toggle");

      // Asynchronous reset with a hit in flight: cleared at once, hit lost.
      left_in = 3; top_in = 3; fsm_out_select_in = 1'b1;
      step();
      #3 rst = 1'b0;
      #1;
      check("arst right", 32'(right_out), 32'h0);
      check("arst C2", cnt_of(2), 32'h0);
      foreach (exp_cnt[k]) exp_cnt[k] = 0;
      left_in = '0; top_in = '0; fsm_out_select_in = 1'b0;
      rst = 1'b1;
      step();
      step();
      check("arst C4", cnt_of(4), 32'h0);
      check_all("arst");

      // Overflow of C14 from 65537 hits of 8+8.
      repeat (65537) apply(8, 8, 1'b1);
      apply(0, 0, 1'b0);
      apply(0, 0, 1'b0);
`ifdef R29_INT4_SAT_EN
      check("ovf C14", cnt_of(14), 32'hFFFF);
`else
      check("ovf C14", cnt_of(14), 32'h0001);
`endif
      check_all("ovf");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_r29_int4
